// File: rtl/pixel_stream_writer.sv
`default_nettype none
// ============================================================================
// pixel_stream_writer : RGB raster stream to frame-buffer write port with
//   8->10 bit channel expansion, framing checks and resync on start-of-frame.
//   Optional self-test frame generator: PIXEL_WRITER_TESTPAT_EN.
// Revision 1.0
// ============================================================================
module pixel_stream_writer #(
    parameter int ROWS = 240,
    parameter int COLS = 32,
    parameter int IN_W = 8
) (
    input  logic            iSysclk,
    input  logic            iRstn,
    input  logic            iValid,
    output logic            oReady,
    input  logic            iSof,
    input  logic            iEol,
    input  logic [IN_W-1:0] iR,
    input  logic [IN_W-1:0] iG,
    input  logic [IN_W-1:0] iB,
    input  logic            iHold,
`ifdef PIXEL_WRITER_TESTPAT_EN
    input  logic            iTestPat,
`endif
    output logic            oWREN,
    output logic [12:0]     oAddress,
    output logic [29:0]     oImage,
    output logic            oFrameDone,
    output logic [7:0]      oErrCnt
);

    localparam int ROW_W = 8;
    localparam int COL_W = 5;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        ST_WAIT_SOF  = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_DROP_LINE = 2'd2,
        ST_TESTPAT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             wren_q, wren_d;
    logic [12:0]      addr_q, addr_d;
    logic [29:0]      image_q, image_d;
    logic             done_q, done_d;
    logic [7:0]       err_q, err_d;

    logic [9:0]       w_r10, w_g10, w_b10;
    logic             w_fire;
    logic             w_write;
    logic             w_busy;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic [1:0]       w_err_inc;
    logic [8:0]       w_err_sum;

    // MSB replication keeps full-scale input at full-scale output.
    generate
        if (IN_W == 10) begin : g_exp_pass
            assign w_r10 = iR;
            assign w_g10 = iG;
            assign w_b10 = iB;
        end else begin : g_exp_rep
            assign w_r10 = {iR, iR[IN_W-1 -: 10-IN_W]};
            assign w_g10 = {iG, iG[IN_W-1 -: 10-IN_W]};
            assign w_b10 = {iB, iB[IN_W-1 -: 10-IN_W]};
        end
    endgenerate

`ifdef PIXEL_WRITER_TESTPAT_EN
    assign w_busy = (state_q == ST_TESTPAT) || ((state_q == ST_WAIT_SOF) && iTestPat);
`else
    assign w_busy = 1'b0;
`endif

    assign oReady = !iHold && iRstn && !w_busy;
    assign w_fire = iValid && oReady;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        image_d   = image_q;
        done_d    = 1'b0;
        w_write   = 1'b0;
        w_row     = row_q;
        w_col     = col_q;
        w_err_inc = 2'd0;

        if (w_fire) begin
            // A start-of-frame always wins and restarts the raster at (0,0).
            if (iSof) begin
                w_write = 1'b1;
                w_row   = '0;
                w_col   = '0;
                if (state_q != ST_WAIT_SOF) begin
                    w_err_inc = w_err_inc + 2'd1;
                end
            end else if (state_q == ST_ACTIVE) begin
                w_write = 1'b1;
            end

            if (w_write) begin
                wren_d  = 1'b1;
                addr_d  = {w_row, w_col};
                image_d = {w_r10, w_g10, w_b10};
                row_d   = w_row;
                state_d = ST_ACTIVE;
                if (iEol) begin
                    if (w_col != LAST_COL) begin
                        w_err_inc = w_err_inc + 2'd1;
                    end
                    col_d = '0;
                    if (w_row == LAST_ROW) begin
                        done_d  = 1'b1;
                        row_d   = '0;
                        state_d = ST_WAIT_SOF;
                    end else begin
                        row_d = w_row + 1'b1;
                    end
                end else if (w_col == LAST_COL) begin
                    w_err_inc = w_err_inc + 2'd1;
                    col_d     = w_col;
                    state_d   = ST_DROP_LINE;
                end else begin
                    col_d = w_col + 1'b1;
                end
            end else if ((state_q == ST_DROP_LINE) && iEol) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    done_d  = 1'b1;
                    row_d   = '0;
                    state_d = ST_WAIT_SOF;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
        end

`ifdef PIXEL_WRITER_TESTPAT_EN
        // row/col are already (0,0) whenever WAIT_SOF is entered.
        if (((state_q == ST_WAIT_SOF) && iTestPat) || (state_q == ST_TESTPAT)) begin
            wren_d  = 1'b1;
            addr_d  = {row_q, col_q};
            image_d = {row_q, 2'b00, col_q, 5'b00000, 10'h000};
            state_d = ST_TESTPAT;
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    done_d  = 1'b1;
                    row_d   = '0;
                    state_d = ST_WAIT_SOF;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
`endif
    end

    assign w_err_sum = {1'b0, err_q} + {7'b0, w_err_inc};
    assign err_d     = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    always_ff @(posedge iSysclk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= ST_WAIT_SOF;
            row_q   <= '0;
            col_q   <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            image_q <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            image_q <= image_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign oWREN      = wren_q;
    assign oAddress   = addr_q;
    assign oImage     = image_q;
    assign oFrameDone = done_q;
    assign oErrCnt    = err_q;

endmodule

`default_nettype wire
